rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and scoreboard for the integer register file. Shares the register file's single write port between the pipeline writeback stage, which always has priority, and a long-latency unit (divider/load unit) that returns results out of band. It also tracks which destination registers have long-latency results outstanding and raises a decode-stage hazard stall. It sits between the writeback stage, the long-latency unit and the register file write port.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers; address width is log2(NREG) = 5
- STARVE_MAX, 4, cycles a buffered long-latency result may wait before a forced bubble is requested

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- wb_valid  in  1  pipeline writeback request; never back-pressured
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback data
- lu_issue_valid  in  1  long-latency op issued this cycle
- lu_issue_rd  in  5  its destination
- lu_issue_ready  out  1  issue accepted
- lu_resp_valid  in  1  long-latency result available
- lu_resp_rd  in  5  result destination
- lu_resp_data  in  XLEN  result data
- lu_resp_ready  out  1  result accepted
- dec_valid  in  1  decode-stage instruction present
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage operands/destination
- hazard_stall  out  1  decode must stall
- bubble_req  out  1  pipeline must insert one writeback bubble
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  XLEN  register file write data

## Operation
- Scoreboard: pending[NREG-1:0]. Issue handshake (lu_issue_valid & lu_issue_ready) with rd != 0 sets pending[rd]; rd = 0 is accepted and sets nothing. A bit clears only when that rd is actually driven onto the write port from the long-latency path, not when it is captured in the buffer.
- lu_issue_ready = !pending[lu_issue_rd]. This is computed from current state, so a same-cycle clear does not raise ready.
- hazard_stall = dec_valid & (pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd]). This covers RAW and WAW. pending[0] is always 0.
- One-entry holding buffer with states EMPTY and HELD.
  - EMPTY: lu_resp_ready = 1.
    - Response with wb_valid = 0: written directly to the port, state stays EMPTY.
    - Response with wb_valid = 1: wb goes to the port, response is captured, state goes to HELD.
  - HELD: lu_resp_ready = 0.
    - wb_valid = 0: buffer drives the port, state goes to EMPTY.
    - wb_valid = 1: state stays HELD and the starve counter increments, saturating at STARVE_MAX.
- Port mux priority: wb, then buffer, then direct lu response. rf_we = 0 when none is active. Writes with address 0 are forwarded unchanged; the register file ignores them.
- bubble_req = HELD & (starve counter == STARVE_MAX). The pipeline must drop wb_valid the following cycle. The counter clears on entering EMPTY.
- Reset (rst = 0 on a clock edge): pending = 0, state EMPTY, counter 0. Any buffered result is discarded; the long-latency unit is reset by the same signal. Reset applies in any state, including HELD.

## Timing
- The rf_* outputs are combinational from current inputs and state, so each write lands in the register file in the same cycle.
- hazard_stall, lu_issue_ready, lu_resp_ready and bubble_req are combinational from registered state plus inputs; no path from lu_resp_valid feeds ready.
- A pending bit clears one edge after the write cycle. hazard_stall therefore stays high through the write cycle and drops in the next cycle, when the register file already holds the value.
- Buffered result latency: 1 cycle minimum; at most STARVE_MAX + 2 cycles once the pipeline honours bubble_req.
- Reset values: rf_we = 0, lu_resp_ready = 1, lu_issue_ready = 1, hazard_stall = 0, bubble_req = 0.

## Structure
- Shared package rf_ctrl_pkg holds XLEN, NREG, REG_AW = 5, and the state enum (EMPTY, HELD).
- Sub-module rf_scoreboard holds the pending vector, the set/clear ports and three lookup ports. The arbiter FSM, buffer and starve counter stay in the top module.

## Test plan
- Issue rd = 5; decode rs1 = 5 → hazard_stall = 1 until the cycle after the response to rd = 5 with data 0xDEADBEEF is written; rf_waddr = 5, rf_wdata = 0xDEADBEEF.
- Response to rd = 7 in the same cycle as wb_valid to rd = 3 → rf writes 3 first, state goes to HELD, and the next idle cycle writes 7; lu_resp_ready = 0 while HELD.
- HELD with wb_valid held high → bubble_req rises after 4 cycles; the bubble drains the buffer and the counter resets to 0.
- Issue rd = 9 twice on consecutive cycles → second issue has lu_issue_ready = 0; issue rd = 0 → ready = 1 and no pending bit is set.
- rst = 0 while HELD with pending[9] set → next cycle: EMPTY, pending = 0, rf_we = 0, all ready outputs = 1.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-port control logic.
package rf_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } buf_state_e;

  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] idx);
    logic [NREG-1:0] one;
    one = {{(NREG-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback, long-latency unit, decode and register-file port bundle for rf_wb_arbiter.
interface rf_wb_arbiter_if;
  import rf_ctrl_pkg::*;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              lu_issue_valid;
  logic [REG_AW-1:0] lu_issue_rd;
  logic              lu_issue_ready;

  logic              lu_resp_valid;
  logic [REG_AW-1:0] lu_resp_rd;
  logic [XLEN-1:0]   lu_resp_data;
  logic              lu_resp_ready;

  logic              dec_valid;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic [REG_AW-1:0] dec_rd;
  logic              hazard_stall;
  logic              bubble_req;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  lu_issue_valid, lu_issue_rd,
    output lu_issue_ready,
    input  lu_resp_valid, lu_resp_rd, lu_resp_data,
    output lu_resp_ready,
    input  dec_valid, dec_rs1, dec_rs2, dec_rd,
    output hazard_stall, bubble_req,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    output lu_issue_valid, lu_issue_rd,
    input  lu_issue_ready,
    output lu_resp_valid, lu_resp_rd, lu_resp_data,
    input  lu_resp_ready,
    output dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  hazard_stall, bubble_req,
    input  rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register with a long-latency
// result outstanding. Register 0 never becomes pending.
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] look_a_idx,
  input  logic [REG_AW-1:0] look_b_idx,
  input  logic [REG_AW-1:0] look_c_idx,
  output logic              look_a_hit,
  output logic              look_b_hit,
  output logic              look_c_hit,
  output logic [NREG-1:0]   pending_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d = pending_d & ~reg_onehot(clr_idx);
    if (set_en) pending_d = pending_d | reg_onehot(set_idx);
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  assign look_a_hit = pending_q[look_a_idx];
  assign look_b_hit = pending_q[look_b_idx];
  assign look_c_hit = pending_q[look_c_idx];
  assign pending_o  = pending_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: writeback always wins, long-latency results go
// direct or through a one-entry buffer; a starve counter requests a writeback bubble.
//   state | meaning
//   EMPTY | buffer free, long-latency responses accepted
//   HELD  | buffer holds a result waiting for an idle write port
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  buf_state_e        state_q, state_d;
  logic [REG_AW-1:0] buf_rd_q, buf_rd_d;
  logic [XLEN-1:0]   buf_data_q, buf_data_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic              issue_ready;
  logic              issue_fire;
  logic              resp_ready;
  logic              resp_fire;
  logic              clr_en;
  logic [REG_AW-1:0] clr_idx;
  logic              rf_we_c;
  logic [REG_AW-1:0] rf_waddr_c;
  logic [XLEN-1:0]   rf_wdata_c;
  logic              hit_rs1, hit_rs2, hit_rd;
  logic [NREG-1:0]   pending;

  rf_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (issue_fire),
    .set_idx    (bus.lu_issue_rd),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx),
    .look_a_idx (bus.dec_rs1),
    .look_b_idx (bus.dec_rs2),
    .look_c_idx (bus.dec_rd),
    .look_a_hit (hit_rs1),
    .look_b_hit (hit_rs2),
    .look_c_hit (hit_rd),
    .pending_o  (pending)
  );

  // Ready depends only on registered state so a response can never gate its own acceptance.
  assign issue_ready = !pending[bus.lu_issue_rd];
  assign issue_fire  = bus.lu_issue_valid && issue_ready;
  assign resp_ready  = (state_q == EMPTY);
  assign resp_fire   = bus.lu_resp_valid && resp_ready;

  always_comb begin
    state_d    = state_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    starve_d   = starve_q;
    clr_en     = 1'b0;
    clr_idx    = '0;
    rf_we_c    = 1'b0;
    rf_waddr_c = '0;
    rf_wdata_c = '0;

    if (bus.wb_valid) begin
      rf_we_c    = 1'b1;
      rf_waddr_c = bus.wb_rd;
      rf_wdata_c = bus.wb_data;
    end else if (state_q == HELD) begin
      rf_we_c    = 1'b1;
      rf_waddr_c = buf_rd_q;
      rf_wdata_c = buf_data_q;
      clr_en     = 1'b1;
      clr_idx    = buf_rd_q;
    end else if (resp_fire) begin
      rf_we_c    = 1'b1;
      rf_waddr_c = bus.lu_resp_rd;
      rf_wdata_c = bus.lu_resp_data;
      clr_en     = 1'b1;
      clr_idx    = bus.lu_resp_rd;
    end

    case (state_q)
      EMPTY: begin
        if (resp_fire && bus.wb_valid) begin
          state_d    = HELD;
          buf_rd_d   = bus.lu_resp_rd;
          buf_data_d = bus.lu_resp_data;
          starve_d   = '0;
        end
      end
      HELD: begin
        if (!bus.wb_valid) begin
          state_d  = EMPTY;
          starve_d = '0;
        end else if (starve_q != STARVE_TOP) begin
          starve_d = starve_q + 1'b1;
        end
      end
      default: begin
        state_d  = EMPTY;
        starve_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      starve_q   <= starve_d;
    end
  end

  assign bus.lu_issue_ready = issue_ready;
  assign bus.lu_resp_ready  = resp_ready;
  assign bus.hazard_stall   = bus.dec_valid && (hit_rs1 || hit_rs2 || hit_rd);
  assign bus.bubble_req     = (state_q == HELD) && (starve_q == STARVE_TOP);
  assign bus.rf_we          = rf_we_c;
  assign bus.rf_waddr       = rf_waddr_c;
  assign bus.rf_wdata       = rf_wdata_c;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; expected register-file writes go through a queue.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  wr_t  exp_q[$];

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // At most one write is queued per cycle; the port must write exactly when one is due.
  task automatic mon(input string tag);
    wr_t e;
    chk({tag, "_we"}, {31'b0, bus.rf_we}, {31'b0, (exp_q.size() != 0)});
    if (bus.rf_we === 1'b1 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_waddr"}, {27'b0, bus.rf_waddr}, {27'b0, e.a});
      chk({tag, "_wdata"}, bus.rf_wdata, e.d);
    end
  endtask

  task automatic idle();
    bus.wb_valid       = 1'b0;
    bus.wb_rd          = '0;
    bus.wb_data        = '0;
    bus.lu_issue_valid = 1'b0;
    bus.lu_issue_rd    = '0;
    bus.lu_resp_valid  = 1'b0;
    bus.lu_resp_rd     = '0;
    bus.lu_resp_data   = '0;
    bus.dec_valid      = 1'b0;
    bus.dec_rs1        = '0;
    bus.dec_rs2        = '0;
    bus.dec_rd         = '0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    idle();
    @(negedge clk);
    #1;
    chk("rst_rf_we", {31'b0, bus.rf_we}, 32'd0);
    chk("rst_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd1);
    chk("rst_issue_ready", {31'b0, bus.lu_issue_ready}, 32'd1);
    chk("rst_hazard", {31'b0, bus.hazard_stall}, 32'd0);
    chk("rst_bubble", {31'b0, bus.bubble_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // issue rd=5
    idle();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd5;
    #1;
    chk("A_issue_ready", {31'b0, bus.lu_issue_ready}, 32'd1);
    mon("A");
    @(negedge clk);

    // decode reads r5 while writeback writes r2
    idle();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd5; bus.dec_rd = 5'd1;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h0000_1111;
    push(5'd2, 32'h0000_1111);
    #1;
    chk("B_hazard", {31'b0, bus.hazard_stall}, 32'd1);
    mon("B");
    @(negedge clk);

    // direct response to r5; stall still high in the write cycle
    idle();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd5; bus.dec_rd = 5'd1;
    bus.lu_resp_valid = 1'b1; bus.lu_resp_rd = 5'd5; bus.lu_resp_data = 32'hDEAD_BEEF;
    push(5'd5, 32'hDEAD_BEEF);
    #1;
    chk("C_hazard", {31'b0, bus.hazard_stall}, 32'd1);
    chk("C_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd1);
    mon("C");
    @(negedge clk);

    idle();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd5; bus.dec_rd = 5'd1;
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd7;
    #1;
    chk("D_hazard", {31'b0, bus.hazard_stall}, 32'd0);
    chk("D_issue_ready", {31'b0, bus.lu_issue_ready}, 32'd1);
    mon("D");
    @(negedge clk);

    // collision: wb r3 wins, response r7 is buffered
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0000_0033;
    bus.lu_resp_valid = 1'b1; bus.lu_resp_rd = 5'd7; bus.lu_resp_data = 32'h0000_0077;
    bus.dec_valid = 1'b1; bus.dec_rs2 = 5'd7;
    push(5'd3, 32'h0000_0033);
    #1;
    chk("E_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd1);
    chk("E_hazard", {31'b0, bus.hazard_stall}, 32'd1);
    mon("E");
    @(negedge clk);

    idle();
    bus.dec_valid = 1'b1; bus.dec_rs2 = 5'd7;
    push(5'd7, 32'h0000_0077);
    #1;
    chk("F_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd0);
    chk("F_hazard", {31'b0, bus.hazard_stall}, 32'd1);
    mon("F");
    @(negedge clk);

    idle();
    bus.dec_valid = 1'b1; bus.dec_rs2 = 5'd7;
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd9;
    #1;
    chk("G_hazard", {31'b0, bus.hazard_stall}, 32'd0);
    chk("G_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd1);
    chk("G_issue_ready", {31'b0, bus.lu_issue_ready}, 32'd1);
    mon("G");
    @(negedge clk);

    // second issue to r9 refused; r9 response buffered behind wb r4
    idle();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd9;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h0000_0044;
    bus.lu_resp_valid = 1'b1; bus.lu_resp_rd = 5'd9; bus.lu_resp_data = 32'h0000_0099;
    push(5'd4, 32'h0000_0044);
    #1;
    chk("H_issue_ready", {31'b0, bus.lu_issue_ready}, 32'd0);
    mon("H");
    @(negedge clk);

    // starve: wb held high; a new response must not be accepted meanwhile
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(10 + i); bus.wb_data = 32'(32'hA0 + i);
      bus.lu_resp_valid = 1'b1; bus.lu_resp_rd = 5'd11; bus.lu_resp_data = 32'h0000_0BAD;
      push(5'(10 + i), 32'(32'hA0 + i));
      #1;
      chk($sformatf("S%0d_bubble", i), {31'b0, bus.bubble_req}, {31'b0, (i == 4)});
      chk($sformatf("S%0d_resp_ready", i), {31'b0, bus.lu_resp_ready}, 32'd0);
      mon($sformatf("S%0d", i));
      @(negedge clk);
    end

    // pipeline honours the bubble; buffer drains r9
    idle();
    push(5'd9, 32'h0000_0099);
    #1;
    chk("K_bubble", {31'b0, bus.bubble_req}, 32'd1);
    chk("K_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd0);
    mon("K");
    @(negedge clk);

    idle();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd0;
    #1;
    chk("L_bubble", {31'b0, bus.bubble_req}, 32'd0);
    chk("L_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd1);
    chk("L_issue0_ready", {31'b0, bus.lu_issue_ready}, 32'd1);
    mon("L");
    @(negedge clk);

    idle();
    bus.dec_valid = 1'b1;
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd9;
    #1;
    chk("M_hazard_r0", {31'b0, bus.hazard_stall}, 32'd0);
    chk("M_issue_ready", {31'b0, bus.lu_issue_ready}, 32'd1);
    mon("M");
    @(negedge clk);

    // enter HELD with r9 pending, then reset
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd12; bus.wb_data = 32'h0000_00CC;
    bus.lu_resp_valid = 1'b1; bus.lu_resp_rd = 5'd20; bus.lu_resp_data = 32'h0000_0020;
    bus.dec_valid = 1'b1; bus.dec_rd = 5'd9;
    push(5'd12, 32'h0000_00CC);
    #1;
    chk("N_hazard_waw", {31'b0, bus.hazard_stall}, 32'd1);
    mon("N");
    @(negedge clk);

    idle();
    rst = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd13; bus.wb_data = 32'h0000_00DD;
    bus.dec_valid = 1'b1; bus.dec_rd = 5'd9;
    bus.lu_issue_rd = 5'd9;
    push(5'd13, 32'h0000_00DD);
    #1;
    chk("P_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd0);
    chk("P_issue_ready", {31'b0, bus.lu_issue_ready}, 32'd0);
    mon("P");
    @(negedge clk);

    idle();
    rst = 1'b1;
    bus.dec_valid = 1'b1; bus.dec_rd = 5'd9;
    bus.lu_issue_rd = 5'd9;
    #1;
    chk("Q_resp_ready", {31'b0, bus.lu_resp_ready}, 32'd1);
    chk("Q_issue_ready", {31'b0, bus.lu_issue_ready}, 32'd1);
    chk("Q_hazard", {31'b0, bus.hazard_stall}, 32'd0);
    chk("Q_bubble", {31'b0, bus.bubble_req}, 32'd0);
    mon("Q");
    @(negedge clk);

    idle();
    #1;
    mon("R");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
